pipe_skid_reg: RTL

- Parametrised successor to the fixed-field inter-stage pipeline registers.
- Single generic stage carrying an opaque DATA_W payload with a valid/ready handshake on both sides.
- Two-entry skid buffer provides full throughput without a combinational ready path from downstream to upstream.
- Keeps the flow-control unit's stall/flush contract (stall beats flush) and adds occupancy and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_skid_reg.sv | 81 ++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Generic pipeline stage: two-entry skid buffer with valid/ready on both sides,
// flow-control stall/flush (stall beats flush), occupancy and a saturating stall counter.
module pipe_skid_reg #(
  parameter int DATA_W         = 32,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up_valid_i,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              up_ready_o,
  output logic              dn_valid_o,
  output logic [DATA_W-1:0] dn_data_o,
  input  logic              dn_ready_i,
  input  logic              fc_stall_i,
  input  logic              fc_flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_d;
  logic [CNT_W-1:0]  stall_cnt;
  logic              up_fire;
  logic              dn_fire;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Ready depends only on registered skid state, never on dn_ready_i.
  assign up_ready_o  = !skid_v && !fc_stall_i;
  assign dn_valid_o  = main_v && !fc_stall_i;
  assign dn_data_o   = main_d;
  assign occ_o       = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_cnt_o = stall_cnt;

  assign up_fire = up_valid_i && up_ready_o;
  assign dn_fire = dn_valid_o && dn_ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_v    <= 1'b0;
      skid_v    <= 1'b0;
      main_d    <= '0;
      skid_d    <= '0;
      stall_cnt <= '0;
    end else if (fc_stall_i) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else if (fc_flush_i) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      if (CLEAR_ON_FLUSH) begin
        main_d <= '0;
        skid_d <= '0;
      end
    end else if (!main_v) begin
      if (up_fire) begin
        main_d <= up_data_i;
        main_v <= 1'b1;
      end
    end else if (!skid_v) begin
      // One entry held: replace, spill into skid, or drain.
      if (up_fire && dn_fire) begin
        main_d <= up_data_i;
      end else if (up_fire) begin
        skid_d <= up_data_i;
        skid_v <= 1'b1;
      end else if (dn_fire) begin
        main_v <= 1'b0;
      end
    end else if (dn_fire) begin
      main_d <= skid_d;
      skid_v <= 1'b0;
    end
  end

endmodule
